// File: rtl/adder_error_monitor.sv
`timescale 1ns/1ps
// adder_error_monitor
// -------------------
// Characterises an approximate N-bit adder. Every accepted sample supplies the
// operands (a, b) and the approximate sum. The exact sum is rebuilt here and
// compared with the approximate one. Over a window of 2^WIN_LOG2 accepted samples
// the block accumulates the error count, the error-distance sum and the maximum
// error distance. The window result, including the mean error distance, is then
// offered on a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   start               begins a new window (only acted on in IDLE)
//   in_valid/in_ready   sample handshake (in_ready is high only in RUN)
//   a, b, approx_sum    operand pair and the approximate sum for that pair
//   res_valid/res_ready result handshake
//   err_count           samples with a nonzero error distance
//   ed_sum              sum of error distances
//   med                 ed_sum >> WIN_LOG2 (floor)
//   max_ed              largest error distance in the window
//   busy                high in any state other than IDLE
module adder_error_monitor #(
    parameter int N        = 8,
    parameter int WIN_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          a,
    input  logic [N-1:0]          b,
    input  logic [N-1:0]          approx_sum,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIN_LOG2:0]     err_count,
    output logic [N+WIN_LOG2-1:0] ed_sum,
    output logic [N-1:0]          med,
    output logic [N-1:0]          max_ed,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [WIN_LOG2-1:0] CNT_ONE = 1;

    state_t                  state_q, state_d;
    logic [WIN_LOG2-1:0]     cnt_q, cnt_d;

    // Stage 1: exact sum and approximate sum, registered on the accept edge
    logic                    s1_valid_q, s1_valid_d;
    logic [N-1:0]            s1_exact_q, s1_exact_d;
    logic [N-1:0]            s1_approx_q, s1_approx_d;

    // Stage 2: window accumulators
    logic [WIN_LOG2:0]       acc_err_q, acc_err_d;
    logic [N+WIN_LOG2-1:0]   acc_sum_q, acc_sum_d;
    logic [N-1:0]            acc_max_q, acc_max_d;

    // Result registers. They are loaded once on the way into REPORT and stay
    // frozen through the whole handshake and afterwards.
    logic [WIN_LOG2:0]       res_err_q, res_err_d;
    logic [N+WIN_LOG2-1:0]   res_sum_q, res_sum_d;
    logic [N-1:0]            res_max_q, res_max_d;
    logic                    res_valid_q, res_valid_d;

    logic                    accept;
    logic                    last_accept;
    logic [N-1:0]            ed;
    logic                    ed_nz;

    assign accept      = (state_q == RUN) && in_valid;
    assign last_accept = accept && (cnt_q == '1);

    // The error distance is a magnitude. The larger value minus the smaller
    // value never wraps.
    always_comb begin
        ed = '0;
        if (s1_exact_q >= s1_approx_q) begin
            ed = s1_exact_q - s1_approx_q;
        end else begin
            ed = s1_approx_q - s1_exact_q;
        end
    end
    assign ed_nz = (ed != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s1_valid_d  = 1'b0;
        s1_exact_d  = s1_exact_q;
        s1_approx_d = s1_approx_q;
        acc_err_d   = acc_err_q;
        acc_sum_d   = acc_sum_q;
        acc_max_d   = acc_max_q;
        res_err_d   = res_err_q;
        res_sum_d   = res_sum_q;
        res_max_d   = res_max_q;
        res_valid_d = 1'b0;

        // Stage 1. The carry-out of a+b is dropped on purpose. A wrapped
        // approximate sum that matches modulo 2^N counts as correct.
        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_exact_d  = a + b;
            s1_approx_d = approx_sum;
        end

        // Stage 2
        if (s1_valid_q) begin
            acc_sum_d = acc_sum_q + {{WIN_LOG2{1'b0}}, ed};
            acc_err_d = acc_err_q + {{WIN_LOG2{1'b0}}, ed_nz};
            if (ed > acc_max_q) begin
                acc_max_d = ed;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    acc_err_d = '0;
                    acc_sum_d = '0;
                    acc_max_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_accept) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last sample clears stage 2 on the cycle that drops
                // s1_valid. After that the accumulators are final.
                if (!s1_valid_q) begin
                    state_d   = REPORT;
                    res_err_d = acc_err_q;
                    res_sum_d = acc_sum_q;
                    res_max_d = acc_max_q;
                end
            end
            REPORT: begin
                if (res_valid_q && res_ready) begin
                    state_d = IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            acc_err_q   <= '0;
            acc_sum_q   <= '0;
            acc_max_q   <= '0;
            res_err_q   <= '0;
            res_sum_q   <= '0;
            res_max_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_exact_q  <= s1_exact_d;
            s1_approx_q <= s1_approx_d;
            acc_err_q   <= acc_err_d;
            acc_sum_q   <= acc_sum_d;
            acc_max_q   <= acc_max_d;
            res_err_q   <= res_err_d;
            res_sum_q   <= res_sum_d;
            res_max_q   <= res_max_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign err_count = res_err_q;
    assign ed_sum    = res_sum_q;
    assign med       = res_sum_q[N+WIN_LOG2-1:WIN_LOG2];
    assign max_ed    = res_max_q;

endmodule

// File: tb/tb_adder_error_monitor.sv
`timescale 1ns/1ps
module tb_adder_error_monitor;

    localparam int N   = 8;
    localparam int WL  = 2;
    localparam int WIN = 1 << WL;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            res_ready = 1'b0;
    logic [N-1:0]    a = '0;
    logic [N-1:0]    b = '0;
    logic [N-1:0]    approx_sum = '0;
    logic            in_ready;
    logic            res_valid;
    logic            busy;
    logic [WL:0]     err_count;
    logic [N+WL-1:0] ed_sum;
    logic [N-1:0]    med;
    logic [N-1:0]    max_ed;

    int checks = 0;
    int failures = 0;
    int cycle_cnt = 0;

    typedef struct {
        int err;
        int sum;
        int med;
        int mx;
        int acc_cycle;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_rv = 1'b0;

    logic [N-1:0] sa [WIN];
    logic [N-1:0] sb [WIN];
    logic [N-1:0] ss [WIN];

    adder_error_monitor #(.N(N), .WIN_LOG2(WL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .err_count  (err_count),
        .ed_sum     (ed_sum),
        .med        (med),
        .max_ed     (max_ed),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact sum modulo 2^N, absolute difference, plain statistics.
    function automatic exp_t model(input int acc_cycle);
        exp_t e;
        e = '{default: 0};
        for (int i = 0; i < WIN; i++) begin
            int ex;
            int d;
            ex = (int'(sa[i]) + int'(sb[i])) % (1 << N);
            d  = (ex > int'(ss[i])) ? ex - int'(ss[i]) : int'(ss[i]) - ex;
            e.sum += d;
            if (d != 0) e.err++;
            if (d > e.mx) e.mx = d;
        end
        e.med = e.sum / WIN;
        e.acc_cycle = acc_cycle;
        return e;
    endfunction

    // Monitor: pops one expectation each time a result is presented.
    always @(negedge clk) begin
        if (res_valid === 1'b1 && prev_rv !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got res_valid=1 expected no result pending");
            end else begin
                mon_e = exp_q.pop_front();
                check("err_count", 64'(err_count), 64'(mon_e.err));
                check("ed_sum",    64'(ed_sum),    64'(mon_e.sum));
                check("med",       64'(med),       64'(mon_e.med));
                check("max_ed",    64'(max_ed),    64'(mon_e.mx));
                check("latency",   64'(cycle_cnt - mon_e.acc_cycle), 64'd3);
                $display("result: err_count=%0d ed_sum=%0d med=%0d max_ed=%0d",
                         err_count, ed_sum, med, max_ed);
            end
        end
        prev_rv <= res_valid;
    end

    task automatic wait_rv();
        int n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_valid_timeout", 64'(res_valid), 64'd1);
    endtask

    task automatic rand_samples();
        for (int i = 0; i < WIN; i++) begin
            sa[i] = N'($urandom);
            sb[i] = N'($urandom);
            case ($urandom_range(0, 2))
                0:       ss[i] = sa[i] + sb[i];
                1:       ss[i] = (sa[i] + sb[i]) ^ N'($urandom_range(1, 7));
                default: ss[i] = N'($urandom);
            endcase
        end
    endtask

    task automatic set_sample(input int i, input logic [N-1:0] va, input logic [N-1:0] vb,
                              input logic [N-1:0] vs);
        sa[i] = va;
        sb[i] = vb;
        ss[i] = vs;
    endtask

    task automatic run_window(input bit gaps, input bit extra, input bit bp);
        int acc = 0;
        int lastc;
        bit drove;
        exp_t e;
        logic [WL:0]     snap_err;
        logic [N+WL-1:0] snap_sum;
        logic [N-1:0]    snap_med, snap_max;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        while (acc < WIN) begin
            drove = !(gaps && $urandom_range(0, 1) == 1);
            in_valid = drove;
            if (drove) begin
                a = sa[acc]; b = sb[acc]; approx_sum = ss[acc];
            end else begin
                a = N'($urandom); b = N'($urandom); approx_sum = N'($urandom);
            end
            check("in_ready_run", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            if (drove) acc++;
        end
        lastc = cycle_cnt;
        e = model(lastc);
        exp_q.push_back(e);
        $display("window: final accept at cycle %0d, expecting err=%0d sum=%0d med=%0d max=%0d",
                 lastc, e.err, e.sum, e.med, e.mx);
        if (extra) begin
            in_valid = 1'b1;
            a = N'($urandom); b = N'($urandom); approx_sum = N'($urandom);
            check("in_ready_drain", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        if (!bp) begin
            res_ready = 1'b1;
            wait_rv();
            @(posedge clk); #1;
            res_ready = 1'b0;
            check("res_valid_after_hs", 64'(res_valid), 64'd0);
            check("busy_after_hs", 64'(busy), 64'd0);
            check("ed_sum_retained", 64'(ed_sum), 64'(e.sum));
        end else begin
            res_ready = 1'b0;
            wait_rv();
            snap_err = err_count; snap_sum = ed_sum; snap_med = med; snap_max = max_ed;
            for (int k = 0; k < 5; k++) begin
                start = 1'b1;
                in_valid = 1'b1;
                a = N'($urandom); b = N'($urandom); approx_sum = N'($urandom);
                @(posedge clk); #1;
                check("bp_res_valid", 64'(res_valid), 64'd1);
                check("bp_in_ready",  64'(in_ready),  64'd0);
                check("bp_busy",      64'(busy),      64'd1);
                check("bp_err",       64'(err_count), 64'(snap_err));
                check("bp_sum",       64'(ed_sum),    64'(snap_sum));
                check("bp_med",       64'(med),       64'(snap_med));
                check("bp_max",       64'(max_ed),    64'(snap_max));
            end
            in_valid = 1'b0;
            res_ready = 1'b1;   // start stays high across the handshake edge
            @(posedge clk); #1;
            res_ready = 1'b0;
            start = 1'b0;
            check("bp_res_valid_after_hs", 64'(res_valid), 64'd0);
            check("bp_busy_after_hs", 64'(busy), 64'd0);
            @(posedge clk); #1;
            check("bp_start_ignored", 64'(busy), 64'd0);
            check("bp_sum_retained", 64'(ed_sum), 64'(e.sum));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N+WL-1:0] held_sum;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_err",       64'(err_count), 64'd0);
        check("rst_sum",       64'(ed_sum),    64'd0);
        check("rst_med",       64'(med),       64'd0);
        check("rst_max",       64'(max_ed),    64'd0);

        // in_valid while IDLE must not be taken
        in_valid = 1'b1; a = 8'h12; b = 8'h34; approx_sum = 8'h00;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_in_ready", 64'(in_ready), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;

        // Known window
        set_sample(0, 8'h30, 8'h05, 8'h35);
        set_sample(1, 8'h47, 8'h70, 8'hB3);
        set_sample(2, 8'h78, 8'h38, 8'hA8);
        set_sample(3, 8'h09, 8'h73, 8'h7F);
        run_window(1'b0, 1'b0, 1'b0);

        // Overflow and extremes, with an extra valid after the last accept
        set_sample(0, 8'hFF, 8'h01, 8'h00);
        set_sample(1, 8'h80, 8'h80, 8'h00);
        set_sample(2, 8'h00, 8'h00, 8'hFF);
        set_sample(3, 8'hFF, 8'hFF, 8'hFE);
        run_window(1'b0, 1'b1, 1'b0);

        // Backpressure
        rand_samples();
        run_window(1'b0, 1'b0, 1'b1);

        // Gaps
        rand_samples();
        run_window(1'b1, 1'b1, 1'b0);

        // IDLE traffic leaves the held result alone
        held_sum = ed_sum;
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; approx_sum = 8'h01;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle2_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check("idle2_sum_unchanged", 64'(ed_sum), 64'(held_sum));

        // Reset mid-run after two accepts
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1; a = N'($urandom); b = N'($urandom); approx_sum = N'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  64'(in_ready),  64'd0);
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_rst_err",       64'(err_count), 64'd0);
        check("mid_rst_sum",       64'(ed_sum),    64'd0);
        check("mid_rst_max",       64'(max_ed),    64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 64'(busy), 64'd0);

        // Fresh zero-error window
        for (int i = 0; i < WIN; i++) begin
            sa[i] = N'($urandom);
            sb[i] = N'($urandom);
            ss[i] = sa[i] + sb[i];
        end
        run_window(1'b1, 1'b0, 1'b0);

        // Random windows
        for (int w = 0; w < 6; w++) begin
            rand_samples();
            run_window(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
